// File: rtl/conv_sequencer_pkg.sv
// ============================================================================
// Module      : conv_sequencer_pkg
// Description : Shared constants and types for the convolution layer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_sequencer_pkg;

    // Config register map shared with the layers block
    localparam int unsigned c_CFG_LAYERS  = 0;
    localparam int unsigned c_CFG_SEQ_WIN = 1;
    localparam int unsigned c_CFG_SEQ_CNT = 2;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = c_ST_IDLE,
        RUN   = c_ST_RUN,
        DRAIN = c_ST_DRAIN,
        DONE  = c_ST_DONE
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/conv_sequencer_seq_counter.sv
// ============================================================================
// Module      : seq_counter
// Description : Clearable up-counter with terminal value; wraps to zero or
//               saturates at the terminal value, flagging the terminal event.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_counter #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_step;
    logic             w_at_term;

    assign w_at_term = (r_count == term);

    // wrap marks the terminal event: returning to zero, or arriving at term
    generate
        if (SATURATE) begin : g_sat
            assign w_step = inc & ~w_at_term;
            assign w_next = r_count + 1'b1;
            assign wrap   = w_step & (r_count == term - 1'b1);
        end else begin : g_wrap
            assign w_step = inc;
            assign w_next = w_at_term ? '0 : r_count + 1'b1;
            assign wrap   = inc & w_at_term;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/conv_sequencer.sv
// ============================================================================
// Module      : conv_sequencer
// Description : Sequences one convolution layer: forwards image beats, marks
//               MAC-window ends, counts passes/results, reports busy/done.
//               Optional stall counter under CONV_SEQ_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] src_data,
    input  logic                          src_val,
    output logic                          src_rdy,
    output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    output logic                          image_last,
    output logic                          image_val,
    input  logic                          image_rdy,
    input  logic                          result_val,
    input  logic                          result_rdy
`ifdef CONV_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt
`endif
);

    seq_state_t  r_state, w_state_next;

    logic [15:0] r_win_len_cfg, r_res_nb_cfg;
    logic [7:0]  r_pool_nb_cfg;
    logic [15:0] r_win_len, r_res_nb;
    logic [7:0]  r_pool_nb;

    logic        w_run, w_launch, w_xfer, w_res_hs, w_res_full, w_clr;
    logic [15:0] w_word_cnt, w_issue_cnt, w_res_cnt;
    logic [7:0]  w_pass_cnt;
    logic        w_word_wrap, w_pass_wrap, w_issue_wrap, w_res_wrap;
    logic        w_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_len_cfg <= '0;
            r_res_nb_cfg  <= '0;
            r_pool_nb_cfg <= '0;
        end else if (cfg_valid) begin
            if (cfg_addr == CFG_AWIDTH'(c_CFG_SEQ_WIN)) begin
                r_win_len_cfg <= cfg_data[15:0];
            end
            if (cfg_addr == CFG_AWIDTH'(c_CFG_SEQ_CNT)) begin
                r_res_nb_cfg  <= cfg_data[15:0];
                r_pool_nb_cfg <= cfg_data[23:16];
            end
        end
    end

    assign w_launch = (r_state == IDLE) & start &
                      (r_win_len_cfg != 16'd0) & (r_res_nb_cfg != 16'd0);

    // Shadow copies let software reprogram the next layer while this one runs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_len <= '0;
            r_res_nb  <= '0;
            r_pool_nb <= '0;
        end else if (w_launch) begin
            r_win_len <= r_win_len_cfg;
            r_res_nb  <= r_res_nb_cfg;
            r_pool_nb <= r_pool_nb_cfg;
        end
    end

    assign w_run    = (r_state == RUN);
    assign w_clr    = (r_state == IDLE);
    assign w_xfer   = w_run & src_val & image_rdy;
    assign w_res_hs = result_val & result_rdy & ((r_state == RUN) | (r_state == DRAIN));

    seq_counter #(.WIDTH(16), .SATURATE(1'b0)) u_word_cnt (
        .clk(clk), .rst(rst), .clr(w_clr), .inc(w_xfer),
        .term(r_win_len - 16'd1), .count(w_word_cnt), .wrap(w_word_wrap)
    );

    seq_counter #(.WIDTH(8), .SATURATE(1'b0)) u_pass_cnt (
        .clk(clk), .rst(rst), .clr(w_clr), .inc(w_word_wrap),
        .term(r_pool_nb), .count(w_pass_cnt), .wrap(w_pass_wrap)
    );

    seq_counter #(.WIDTH(16), .SATURATE(1'b1)) u_issue_cnt (
        .clk(clk), .rst(rst), .clr(w_clr), .inc(w_pass_wrap),
        .term(r_res_nb), .count(w_issue_cnt), .wrap(w_issue_wrap)
    );

    seq_counter #(.WIDTH(16), .SATURATE(1'b1)) u_res_cnt (
        .clk(clk), .rst(rst), .clr(w_clr), .inc(w_res_hs),
        .term(r_res_nb), .count(w_res_cnt), .wrap(w_res_wrap)
    );

    // Include this cycle's handshake so done follows the final result by one cycle
    assign w_res_full = (w_res_cnt == r_res_nb) | w_res_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_launch)     w_state_next = RUN;
            RUN:     if (w_issue_wrap) w_state_next = DRAIN;
            DRAIN:   if (w_res_full)   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign src_rdy    = w_run & image_rdy;
    assign image_val  = w_run & src_val;
    assign image_bus  = src_data;
    assign image_last = image_val & (w_word_cnt == r_win_len - 16'd1);

`ifdef CONV_SEQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_launch) begin
            r_stall_cnt <= '0;
        end else if (w_run && src_val && !image_rdy) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    // Bits with no consumer, gathered in one place
    assign w_unused = ^{cfg_data[CFG_DWIDTH-1:24], w_pass_cnt, w_issue_cnt};

endmodule

`default_nettype wire
